// File: rtl/uart_send_if.sv
// Byte handshake between the CPU/MMIO side (master) and the uart_send transmitter (slave).
interface uart_send_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_send.sv
// 8N1 UART transmitter with a small byte FIFO; frames are sent back-to-back, LSB first.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_send #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int UART_BPS   = 128000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  uart_send_if.slave                  tx,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic                        uart_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FCNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BPS_CNT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] count;
  logic              push, pop, empty;

  // Ready is decoded from the registered count only, so a same-cycle pop never admits a push when full.
  assign tx.tx_ready = (count != FIFO_FULL);
  assign push        = tx.tx_valid && tx.tx_ready;
  assign empty       = (count == '0);
  assign fifo_cnt    = count;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= tx.tx_data;
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nx;
  logic [2:0]       bit_cnt, bit_cnt_nx;
  logic [7:0]       shift, shift_nx;
  logic             txd_nx;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par, par_nx;
`endif

  assign bit_end   = (clk_cnt == BIT_LAST);
  assign tx_busy   = (state != IDLE);
  assign uart_done = (state == STOP) && bit_end;

  always_comb begin
    state_nx   = state;
    clk_cnt_nx = bit_end ? '0 : clk_cnt + 1'b1;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    txd_nx     = uart_txd;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nx     = par;
`endif
    case (state)
      IDLE: begin
        clk_cnt_nx = '0;
        txd_nx     = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
          par_nx   = ^mem[rd_ptr];
`endif
          state_nx = START;
          txd_nx   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
          txd_nx     = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nx   = shift >> 1;
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
            txd_nx   = par;
`else
            state_nx = STOP;
            txd_nx   = 1'b1;
`endif
          end else begin
            txd_nx = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nx = STOP;
          txd_nx   = 1'b1;
        end
      end
`endif
      STOP: begin
        // A queued byte starts on the very next clock, so consecutive frames share no idle bit.
        if (bit_end) begin
          if (!empty) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par_nx   = ^mem[rd_ptr];
`endif
            state_nx = START;
            txd_nx   = 1'b0;
          end else begin
            state_nx = IDLE;
            txd_nx   = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        txd_nx   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_nx;
      clk_cnt  <= clk_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      uart_txd <= txd_nx;
    end
  end

  always_ff @(posedge sys_clk) begin
    shift <= shift_nx;
`ifdef UART_TX_PARITY_EN
    par   <= par_nx;
`endif
  end

endmodule

// File: tb/tb_uart_send.sv
// Randomized bench for uart_send: every cycle the line, busy, done, occupancy and ready are compared
// against a frame-schedule model (each accepted byte owns a start time and a fixed-length frame).
module tb_uart_send;
  localparam int CLK_FREQ = 1250;
  localparam int UART_BPS = 100;
  localparam int DEPTH    = 4;
  localparam int BPS      = CLK_FREQ / UART_BPS;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BPS;

  logic                   sys_clk = 1'b0;
  logic                   sys_rst;
  logic                   uart_txd, tx_busy, uart_done;
  logic [$clog2(DEPTH):0] fifo_cnt;

  uart_send_if tx_if ();

  uart_send #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BPS  (UART_BPS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .tx       (tx_if),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .uart_done(uart_done),
    .fifo_cnt (fifo_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         s;
    logic [7:0] d;
  } frame_t;

  frame_t frames[$];
  int     cyc      = 0;
  int     last_end = 0;
  int     last_s   = 0;
  int     n_vec    = 0;
  int     n_err    = 0;
  int     peak     = 0;
  int     done_seen = 0;
  int     n_acc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic int queued();
    int n = 0;
    foreach (frames[i]) if (frames[i].s > cyc) n++;
    return n;
  endfunction

  task automatic check_cycle();
    logic e_txd, e_busy, e_done;
    while (frames.size() > 0 && frames[0].s + FRAME <= cyc) void'(frames.pop_front());
    e_txd  = 1'b1;
    e_busy = 1'b0;
    e_done = 1'b0;
    foreach (frames[i]) begin
      if (frames[i].s <= cyc) begin
        e_busy = 1'b1;
        e_txd  = frame_bit(frames[i].d, (cyc - frames[i].s) / BPS);
        e_done = (cyc == frames[i].s + FRAME - 1);
      end
    end
    check("txd",   uart_txd,  e_txd);
    check("busy",  tx_busy,   e_busy);
    check("done",  uart_done, e_done);
    check("cnt",   fifo_cnt,  queued());
    check("ready", tx_if.tx_ready, queued() < DEPTH);
    if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
    if (uart_done === 1'b1) done_seen++;
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare at the falling edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic r, output logic acc);
    int s;
    tx_if.tx_valid = v;
    tx_if.tx_data  = d;
    sys_rst        = r;
    acc = v && !r && (queued() < DEPTH);
    @(posedge sys_clk);
    cyc++;
    if (r) begin
      frames.delete();
      last_end = 0;
    end else if (acc) begin
      s = (cyc + 1 > last_end) ? cyc + 1 : last_end;
      frames.push_back('{s: s, d: d});
      last_end = s + FRAME;
      last_s   = s;
      n_acc++;
    end
    @(negedge sys_clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, a);
  endtask

  initial begin
    logic       a;
    logic [7:0] burst [6];
    logic [7:0] trio  [3];
    int         k;
    int         s0;
    int         hi_rate;

    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    sys_rst        = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1, a);
    idle(2);

    // Single 0x55 frame.
    done_seen = 0;
    tick(1'b1, 8'h55, 1'b0, a);
    idle(FRAME + 10);
    check("single_done_count", done_seen, 1);

    // Three back-to-back frames.
    trio[0] = 8'hA5; trio[1] = 8'h3C; trio[2] = 8'hFF;
    done_seen = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, trio[i], 1'b0, a);
    idle(3 * FRAME + 10);
    check("trio_done_count", done_seen, 3);

    // Hold valid with six distinct bytes; the FIFO fills and the pointers wrap.
    for (int i = 0; i < 6; i++) burst[i] = 8'(8'h11 * (i + 1));
    peak = 0;
    n_acc = 0;
    k = 0;
    for (int i = 0; i < 2000 && k < 6; i++) begin
      tick(1'b1, burst[k], 1'b0, a);
      if (a) k++;
    end
    check("hold_accepted", k, 6);
    check("fifo_peak", peak, DEPTH);
    idle(6 * FRAME + 10);

    // Reset during data bit 3 of 0x00 with two bytes queued behind it.
    tick(1'b1, 8'h00, 1'b0, a);
    s0 = last_s;
    tick(1'b1, 8'hC3, 1'b0, a);
    tick(1'b1, 8'h5A, 1'b0, a);
    for (int i = 0; i < 1000 && cyc < s0 + 4 * BPS + BPS / 2; i++) idle(1);
    check("rst_pre_cnt", fifo_cnt, 2);
    done_seen = 0;
    tick(1'b0, 8'h00, 1'b1, a);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_cnt", fifo_cnt, 0);
    idle(2 * FRAME);
    check("rst_no_done", done_seen, 0);

    // Parity-sensitive bytes (odd and even weight).
    tick(1'b1, 8'h07, 1'b0, a);
    tick(1'b1, 8'h03, 1'b0, a);
    idle(2 * FRAME + 10);

    // Random traffic with alternating push density and rare resets.
    hi_rate = 1;
    for (int i = 0; i < 5000; i++) begin
      if (i % 700 == 0) hi_rate = $urandom_range(0, 1);
      tick(hi_rate ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0),
           8'($urandom), ($urandom_range(0, 1499) == 0), a);
    end
    idle((DEPTH + 1) * FRAME + 10);
    check("final_idle", tx_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
